hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall and forwarding-select generator for a five-stage MIPS pipeline.
// Tracks destination register, result source and derived Tnew for the E, M and W
// stages. These are compared against operand demand (Tuse) from D, E and M.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   rs_D, rt_D                 source registers of the D instruction
//   tuse_rs_D, tuse_rt_D       cycles until each operand is consumed (3 = unused)
//   a3_D, src_D                destination register and result source of D
//   stall                      freeze PC/D, inject bubble into E
//   F_CMP_A_D, F_CMP_B_D       comparator operand bypass selects
//   F_ALU_A_E, F_ALU_B_E       ALU operand bypass selects
//   F_DM_Data_M                store-data bypass select
//   stall_cnt                  saturating stall-cycle counter (only with HAZARD_STALL_CNT_EN)
//
// Optional feature macro: HAZARD_STALL_CNT_EN
module hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] tuse_rs_D,
  input  logic [1:0] tuse_rt_D,
  input  logic [4:0] a3_D,
  input  logic [1:0] src_D,
  output logic       stall,
  output logic [2:0] F_CMP_A_D,
  output logic [2:0] F_CMP_B_D,
  output logic [1:0] F_ALU_A_E,
  output logic [1:0] F_ALU_B_E,
  output logic [1:0] F_DM_Data_M
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned SRC_W  = 2;
  localparam int unsigned TNEW_W = 2;
  localparam int unsigned CNT_W  = 32;

  localparam logic [SRC_W-1:0] SRC_DM   = 2'b01;
  localparam logic [SRC_W-1:0] SRC_LINK = 2'b10;

  // Stage records
  logic [REG_W-1:0] e_rs_q, e_rt_q, e_a3_q;
  logic [SRC_W-1:0] e_src_q;
  logic [REG_W-1:0] m_rt_q, m_a3_q;
  logic [SRC_W-1:0] m_src_q;
  logic [REG_W-1:0] w_a3_q;
  logic [SRC_W-1:0] w_src_q;

  logic [REG_W-1:0] e_rs_d, e_rt_d, e_a3_d;
  logic [SRC_W-1:0] e_src_d;

  logic [TNEW_W-1:0] tnew_e, tnew_m;

  // Remaining result latency in E: LINK known already, ALU after E, load after M
  function automatic logic [TNEW_W-1:0] calc_tnew_e(input logic [SRC_W-1:0] src);
    logic [TNEW_W-1:0] t;
    t = TNEW_W'(1);
    if (src == SRC_DM)        t = TNEW_W'(2);
    else if (src == SRC_LINK) t = TNEW_W'(0);
    return t;
  endfunction

  function automatic logic op_stall(input logic [REG_W-1:0]  r,
                                    input logic [1:0]        tuse,
                                    input logic [REG_W-1:0]  a3e,
                                    input logic [TNEW_W-1:0] tne,
                                    input logic [REG_W-1:0]  a3m,
                                    input logic [TNEW_W-1:0] tnm);
    logic s;
    s = 1'b0;
    if (r != '0 && tuse != 2'd3) begin
      if (a3e == r && tne > tuse) s = 1'b1;
      if (a3m == r && tnm > tuse) s = 1'b1;
    end
    return s;
  endfunction

  // Comparator select: nearest producer wins; a not-yet-ready producer yields 000
  function automatic logic [2:0] cmp_sel(input logic [REG_W-1:0] r,
                                         input logic [REG_W-1:0] a3e,
                                         input logic [SRC_W-1:0] srce,
                                         input logic [REG_W-1:0] a3m,
                                         input logic [SRC_W-1:0] srcm,
                                         input logic [REG_W-1:0] a3w,
                                         input logic [SRC_W-1:0] srcw);
    logic [2:0] s;
    s = 3'b000;
    if (r == '0) begin
      s = 3'b000;
    end else if (a3e == r) begin
      s = (srce == SRC_LINK) ? 3'b111 : 3'b000;
    end else if (a3m == r) begin
      if (srcm == SRC_LINK)    s = 3'b101;
      else if (srcm == SRC_DM) s = 3'b000;
      else                     s = 3'b110;
    end else if (a3w == r) begin
      if (srcw == SRC_LINK)    s = 3'b011;
      else if (srcw == SRC_DM) s = 3'b010;
      else                     s = 3'b100;
    end
    return s;
  endfunction

  // W-stage select shared by ALU and store-data paths
  function automatic logic [1:0] w_sel(input logic [REG_W-1:0] r,
                                       input logic [REG_W-1:0] a3w,
                                       input logic [SRC_W-1:0] srcw);
    logic [1:0] s;
    s = 2'b00;
    if (r != '0 && a3w == r) s = (srcw == SRC_DM) ? 2'b01 : 2'b10;
    return s;
  endfunction

  // ALU select: M result usable unless it is a load still in flight
  function automatic logic [1:0] alu_sel(input logic [REG_W-1:0] r,
                                         input logic [REG_W-1:0] a3m,
                                         input logic [SRC_W-1:0] srcm,
                                         input logic [REG_W-1:0] a3w,
                                         input logic [SRC_W-1:0] srcw);
    logic [1:0] s;
    s = w_sel(r, a3w, srcw);
    if (r != '0 && a3m == r && srcm != SRC_DM) s = 2'b11;
    return s;
  endfunction

  // Tnew derivation and stall
  always_comb begin
    tnew_e = calc_tnew_e(e_src_q);
    tnew_m = (m_src_q == SRC_DM) ? TNEW_W'(1) : TNEW_W'(0);
    stall  = op_stall(rs_D, tuse_rs_D, e_a3_q, tnew_e, m_a3_q, tnew_m) |
             op_stall(rt_D, tuse_rt_D, e_a3_q, tnew_e, m_a3_q, tnew_m);
  end

  // Bypass selects
  always_comb begin
    F_CMP_A_D   = cmp_sel(rs_D, e_a3_q, e_src_q, m_a3_q, m_src_q, w_a3_q, w_src_q);
    F_CMP_B_D   = cmp_sel(rt_D, e_a3_q, e_src_q, m_a3_q, m_src_q, w_a3_q, w_src_q);
    F_ALU_A_E   = alu_sel(e_rs_q, m_a3_q, m_src_q, w_a3_q, w_src_q);
    F_ALU_B_E   = alu_sel(e_rt_q, m_a3_q, m_src_q, w_a3_q, w_src_q);
    F_DM_Data_M = w_sel(m_rt_q, w_a3_q, w_src_q);
  end

  // E record loads a bubble while stalled
  always_comb begin
    e_rs_d  = rs_D;
    e_rt_d  = rt_D;
    e_a3_d  = a3_D;
    e_src_d = src_D;
    if (stall) begin
      e_rs_d  = '0;
      e_rt_d  = '0;
      e_a3_d  = '0;
      e_src_d = '0;
    end
  end

  // Stage record pipeline
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_rs_q  <= '0;
      e_rt_q  <= '0;
      e_a3_q  <= '0;
      e_src_q <= '0;
      m_rt_q  <= '0;
      m_a3_q  <= '0;
      m_src_q <= '0;
      w_a3_q  <= '0;
      w_src_q <= '0;
    end else begin
      e_rs_q  <= e_rs_d;
      e_rt_q  <= e_rt_d;
      e_a3_q  <= e_a3_d;
      e_src_q <= e_src_d;
      m_rt_q  <= e_rt_q;
      m_a3_q  <= e_a3_q;
      m_src_q <= e_src_q;
      w_a3_q  <= m_a3_q;
      w_src_q <= m_src_q;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of stalled cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios plus random
// instruction streams, compared against a stage-readiness model.
module tb_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] a3;
    logic [1:0] src;
  } rec_t;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] tu_rs;
    logic [1:0] tu_rt;
    logic [4:0] a3;
    logic [1:0] src;
  } din_t;

  logic       clk;
  logic       reset;
  logic [4:0] rs_D, rt_D, a3_D;
  logic [1:0] tuse_rs_D, tuse_rt_D, src_D;
  logic       stall;
  logic [2:0] F_CMP_A_D, F_CMP_B_D;
  logic [1:0] F_ALU_A_E, F_ALU_B_E, F_DM_Data_M;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  hazard_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .rs_D        (rs_D),
    .rt_D        (rt_D),
    .tuse_rs_D   (tuse_rs_D),
    .tuse_rt_D   (tuse_rt_D),
    .a3_D        (a3_D),
    .src_D       (src_D),
    .stall       (stall),
    .F_CMP_A_D   (F_CMP_A_D),
    .F_CMP_B_D   (F_CMP_B_D),
    .F_ALU_A_E   (F_ALU_A_E),
    .F_ALU_B_E   (F_ALU_B_E),
    .F_DM_Data_M (F_DM_Data_M)
`ifdef HAZARD_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: pipe[1]=E, pipe[2]=M, pipe[3]=W
  rec_t        pipe [1:3];
  logic        exp_stall;
  longint      exp_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Stage index at which a result can be read from a pipeline register
  function automatic int ready_stage(input logic [1:0] src);
    if (src == 2'b01) return 3;
    if (src == 2'b10) return 1;
    return 2;
  endfunction

  function automatic int tnew(input int stg, input logic [1:0] src);
    int r;
    r = ready_stage(src);
    return (r > stg) ? r - stg : 0;
  endfunction

  function automatic logic m_stall(input din_t d);
    logic       s;
    logic [4:0] r;
    logic [1:0] tu;
    s = 1'b0;
    for (int k = 0; k < 2; k++) begin
      r  = (k == 0) ? d.rs : d.rt;
      tu = (k == 0) ? d.tu_rs : d.tu_rt;
      if (r != 0 && tu != 2'd3)
        for (int stg = 1; stg <= 2; stg++)
          if (pipe[stg].a3 == r && tnew(stg, pipe[stg].src) > int'(tu)) s = 1'b1;
    end
    return s;
  endfunction

  function automatic logic [2:0] m_cmp(input logic [4:0] r);
    if (r == 0) return 3'd0;
    for (int stg = 1; stg <= 3; stg++) begin
      if (pipe[stg].a3 == r) begin
        if (tnew(stg, pipe[stg].src) > 0) return 3'd0;
        case (stg)
          1: return 3'd7;
          2: return (pipe[stg].src == 2'b10) ? 3'd5 : 3'd6;
          default: begin
            if (pipe[stg].src == 2'b01) return 3'd2;
            if (pipe[stg].src == 2'b10) return 3'd3;
            return 3'd4;
          end
        endcase
      end
    end
    return 3'd0;
  endfunction

  // Later-stage consumer: take the nearest ready producer from first_stg onward
  function automatic logic [1:0] m_late(input logic [4:0] r, input int first_stg);
    if (r == 0) return 2'd0;
    for (int stg = first_stg; stg <= 3; stg++)
      if (pipe[stg].a3 == r && tnew(stg, pipe[stg].src) == 0) begin
        if (stg == 2) return 2'd3;
        return (pipe[stg].src == 2'b01) ? 2'd1 : 2'd2;
      end
    return 2'd0;
  endfunction

  task automatic model_clear();
    for (int i = 1; i <= 3; i++) pipe[i] = '0;
    exp_cnt = 0;
  endtask

  task automatic drive(input din_t d);
    rs_D      = d.rs;
    rt_D      = d.rt;
    tuse_rs_D = d.tu_rs;
    tuse_rt_D = d.tu_rt;
    a3_D      = d.a3;
    src_D     = d.src;
  endtask

  task automatic check_all(input din_t d);
    exp_stall = m_stall(d);
    chk("stall", 32'(stall), 32'(exp_stall));
    chk("cmp_a", 32'(F_CMP_A_D), 32'(m_cmp(d.rs)));
    chk("cmp_b", 32'(F_CMP_B_D), 32'(m_cmp(d.rt)));
    chk("alu_a", 32'(F_ALU_A_E), 32'(m_late(pipe[1].rs, 2)));
    chk("alu_b", 32'(F_ALU_B_E), 32'(m_late(pipe[1].rt, 2)));
    chk("dm_data", 32'(F_DM_Data_M), 32'(m_late(pipe[2].rt, 3)));
`ifdef HAZARD_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, 32'(exp_cnt));
`endif
  endtask

  // One pipeline cycle: drive D, check mid-cycle, advance model at the edge
  task automatic step(input din_t d);
    #1 drive(d);
    @(negedge clk);
    check_all(d);
    @(posedge clk);
    pipe[3] = pipe[2];
    pipe[2] = pipe[1];
    pipe[1] = exp_stall ? rec_t'(0) : rec_t'({d.rs, d.rt, d.a3, d.src});
    if (exp_stall && exp_cnt < 64'hFFFF_FFFF) exp_cnt++;
  endtask

  function automatic din_t mk(input logic [4:0] rs, input logic [1:0] tu_rs,
                              input logic [4:0] rt, input logic [1:0] tu_rt,
                              input logic [4:0] a3, input logic [1:0] src);
    din_t d;
    d.rs = rs; d.tu_rs = tu_rs; d.rt = rt; d.tu_rt = tu_rt; d.a3 = a3; d.src = src;
    return d;
  endfunction

  din_t nop, cur;

  initial begin
    nop = mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0);
    drive(nop);
    reset = 1'b1;
    model_clear();
    exp_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_all(nop);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);

    // Reset mid-stall: load to $5 in E, dependent branch in D
    step(mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'b01));
    #1 drive(mk(5'd5, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0));
    @(negedge clk);
    chk("rst_pre_stall", 32'(stall), 32'd1);
    #2 reset = 1'b1;
    #1 model_clear();
    check_all(mk(5'd5, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0));
    chk("rst_stall", 32'(stall), 32'd0);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    step(mk(5'd5, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0));
    chk("rst_release_stall", 32'(stall), 32'd0);

    // Load then branch: two stalls, then DM_W bypass
    step(mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'b01));
    cur = mk(5'd5, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0);
    step(cur); chk("ld_br_stall1", 32'(stall), 32'd1);
    step(cur); chk("ld_br_stall2", 32'(stall), 32'd1);
    step(cur); chk("ld_br_go", 32'(stall), 32'd0);
    chk("ld_br_cmp", 32'(F_CMP_A_D), 32'd2);

    // ALU then branch: one stall, then ALUout_M bypass
    step(mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 2'b00));
    cur = mk(5'd3, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0);
    step(cur); chk("alu_br_stall", 32'(stall), 32'd1);
    step(cur); chk("alu_br_go", 32'(stall), 32'd0);
    chk("alu_br_cmp", 32'(F_CMP_A_D), 32'd6);
`ifdef HAZARD_STALL_CNT_EN
    chk("stall_cnt_3", stall_cnt, 32'd3);
`endif

    // Load-use to ALU
    step(mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'b01));
    cur = mk(5'd8, 2'd1, 5'd0, 2'd3, 5'd9, 2'b00);
    step(cur); chk("ld_use_stall", 32'(stall), 32'd1);
    step(cur); chk("ld_use_go", 32'(stall), 32'd0);
    step(nop); chk("ld_use_alu_a", 32'(F_ALU_A_E), 32'd1);

    // jal then jr
    step(mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd31, 2'b10));
    step(mk(5'd31, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0));
    chk("jal_stall", 32'(stall), 32'd0);
    chk("jal_cmp", 32'(F_CMP_A_D), 32'd7);

    // Load then store of the loaded register
    step(mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd4, 2'b01));
    step(mk(5'd0, 2'd3, 5'd4, 2'd2, 5'd0, 2'd0));
    chk("sw_stall", 32'(stall), 32'd0);
    step(nop);
    step(nop);
    chk("sw_dm_data", 32'(F_DM_Data_M), 32'd1);

    // $0 writer then $0 reader
    step(mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'b00));
    step(mk(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0));
    chk("r0_stall", 32'(stall), 32'd0);
    chk("r0_cmp", 32'(F_CMP_A_D), 32'd0);

    // Random streams over a small register set; D holds while stalled
    exp_stall = 1'b0;
    cur = nop;
    for (int n = 0; n < 400; n++) begin
      if (!exp_stall) begin
        cur.rs    = 5'($urandom_range(0, 4));
        cur.rt    = 5'($urandom_range(0, 4));
        cur.tu_rs = 2'($urandom_range(0, 3));
        cur.tu_rt = 2'($urandom_range(0, 3));
        cur.a3    = 5'($urandom_range(0, 4));
        cur.src   = 2'($urandom_range(0, 3));
      end
      step(cur);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
